// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver (8 data bits, LSB first,
// optional parity, one stop bit) feeding a small receive FIFO that is read
// over a valid/ready handshake.
//
// Ports:
//   io_clk, io_rst  clock (rising edge) and synchronous active-high reset
//   baud_div        clocks per oversample tick minus 1 (change only when idle)
//   parity_en       a parity bit follows the data bits
//   parity_odd      1 = odd parity, 0 = even parity
//   rx              asynchronous serial input, idle high
//   rx_data         byte at the FIFO head (holds its value when empty)
//   rx_valid        FIFO not empty
//   rx_ready        consumer accepts rx_data when rx_valid is also high
//   frame_err       one-cycle pulse: stop bit sampled low
//   parity_err      one-cycle pulse: parity mismatch
//   overrun         one-cycle pulse: byte dropped because the FIFO was full
//   busy            receiver is not idle
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             io_clk,
  input  logic             io_rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  // ---------------- input synchroniser ----------------
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------- oversample tick ----------------
  logic [DIV_W-1:0] tick_cnt_q;
  logic             tick;

  // '>=' rather than '==' so a divisor lowered below the running count
  // reloads immediately instead of wrapping the whole counter range.
  assign tick = (tick_cnt_q >= baud_div);

  always_ff @(posedge io_clk) begin
    if (io_rst || tick) tick_cnt_q <= '0;
    else                tick_cnt_q <= tick_cnt_q + DIV_W'(1);
  end

  // ---------------- receiver FSM ----------------
  state_t     state_q;
  logic [3:0] s_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shreg_q;
  logic [1:0] samp_q;      // [0] = sample at s=7, [1] = sample at s=8
  logic       par_bad_q;
  logic       push_q;
  logic       frame_err_q, parity_err_q;
  logic       maj;

  // Majority of the s=7 and s=8 samples and the live s=9 sample.
  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      state_q      <= S_IDLE;
      s_q          <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      samp_q       <= 2'b11;
      par_bad_q    <= 1'b0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;

      if (tick && state_q != S_IDLE) s_q <= s_q + 4'd1;
      if (tick && s_q == 4'd7) samp_q[0] <= rx_s_q;
      if (tick && s_q == 4'd8) samp_q[1] <= rx_s_q;

      case (state_q)
        S_IDLE: begin
          if (tick && !rx_s_q) begin
            state_q   <= S_START;
            s_q       <= '0;
            bit_idx_q <= '0;
            par_bad_q <= 1'b0;
          end
        end
        S_START: begin
          if (tick && s_q == 4'd9 && maj) begin
            state_q <= S_IDLE;              // start bit too short: glitch
          end else if (tick && s_q == 4'd15) begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
          end
        end
        S_DATA: begin
          if (tick && s_q == 4'd9) shreg_q <= {maj, shreg_q[7:1]};
          if (tick && s_q == 4'd15) begin
            if (bit_idx_q == 3'd7) state_q <= parity_en ? S_PARITY : S_STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        S_PARITY: begin
          if (tick && s_q == 4'd9)  par_bad_q <= (maj != ((^shreg_q) ^ parity_odd));
          if (tick && s_q == 4'd15) state_q <= S_STOP;
        end
        S_STOP: begin
          // Leave at mid-stop so a start bit right after the stop bit is caught.
          if (tick && s_q == 4'd9) begin
            parity_err_q <= par_bad_q;
            if (maj) begin
              push_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

  // ---------------- receive FIFO ----------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, after_pop;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             overrun_q, overrun_d;
  logic             pop, full, push_ok;

  always_comb begin
    pop       = (count_q != '0) & rx_ready;
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    push_ok   = push_q & (~full | pop);
    overrun_d = push_q & full & ~pop;
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok);
    after_pop = count_q - CNT_W'(pop);
    count_d   = after_pop + CNT_W'(push_ok);
    // Head after this cycle: the incoming byte bypasses the array when it
    // lands in an otherwise empty FIFO; an empty FIFO keeps the old value.
    rx_data_d = rx_data_q;
    if (count_d != '0) begin
      if (after_pop == '0) rx_data_d = shreg_q;
      else                 rx_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge io_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
  end

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rx_data_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rx_data_q <= rx_data_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = (count_q != '0);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: the stimulus side pushes expected bytes
// and error-pulse totals; a negedge monitor pops and compares on handshakes.
module tb_uart_rx_fifo;
  localparam int DEPTH = 4;

  logic        io_clk = 1'b0;
  logic        io_rst = 1'b1;
  logic [15:0] baud_div = '0;
  logic        parity_en = 1'b0, parity_odd = 1'b0, rx = 1'b1, rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, parity_err, overrun, busy;

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .io_clk(io_clk), .io_rst(io_rst), .baud_div(baud_div),
    .parity_en(parity_en), .parity_odd(parity_odd), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
    .busy(busy)
  );

  always #5 io_clk = ~io_clk;

  int checks = 0, errors = 0;
  byte unsigned exp_q[$];
  int occ = 0;                       // model FIFO occupancy
  int n_frame = 0, n_par = 0, n_ovr = 0;
  int e_frame = 0, e_par = 0, e_ovr = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: counts pulses and checks every accepted byte.
  always @(negedge io_clk) begin : monitor
    byte unsigned e;
    if (!io_rst) begin
      if (frame_err)  n_frame++;
      if (parity_err) n_par++;
      if (overrun)    n_ovr++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h, expected none", rx_data);
        end else begin
          e = exp_q.pop_front();
          occ--;
          $display("RX byte %02h (expected %02h)", rx_data, e);
          chk("rx_data", int'(rx_data), int'(e));
        end
      end
    end
  end

  task automatic step();
    @(posedge io_clk);
    #1;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_bits(input logic [11:0] bits, input int n);
    int bc;
    bc = 16 * (int'(baud_div) + 1);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      for (int j = 0; j < bc; j++) step();
    end
  endtask

  function automatic logic [11:0] frame_bits(input byte unsigned d, input bit pen,
                                             input bit pbit, input bit stop);
    logic [11:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    if (pen) begin
      b[9]  = pbit;
      b[10] = stop;
    end else begin
      b[9] = stop;
    end
    return b;
  endfunction

  task automatic send_frame(input byte unsigned d, input bit pen, input bit pbit, input bit stop);
    int ones;
    bit good;
    ones = $countones(d) + int'(pbit);
    good = ((ones % 2) == (parity_odd ? 1 : 0));
    if (pen && !good) e_par++;
    if (!stop) e_frame++;
    else if (occ == DEPTH) e_ovr++;
    else begin
      exp_q.push_back(d);
      occ++;
    end
    $display("TX byte %02h pen=%0b par=%0b stop=%0b div=%0d", d, pen, pbit, stop, baud_div);
    drive_bits(frame_bits(d, pen, pbit, stop), pen ? 11 : 10);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic chk_counts(input string tag);
    repeat (4) step();
    chk({tag, "_frame_err"}, n_frame, e_frame);
    chk({tag, "_parity_err"}, n_par, e_par);
    chk({tag, "_overrun"}, n_ovr, e_ovr);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit saw_busy;
    bit pen, pbit, stop;
    byte unsigned d;
    logic [11:0] fb;

    // Reset state
    repeat (3) step();
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_data", int'(rx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_errs", int'({frame_err, parity_err, overrun}), 0);
    io_rst = 1'b0;
    repeat (5) step();

    // Basic receive 0xAA 8N1
    rx_ready = 1'b1;
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
    chk("basic_busy_idle", int'(busy), 0);
    wait_drain("basic_drain");
    chk_counts("basic");

    // Back-to-back burst into a stalled consumer
    rx_ready = 1'b0;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1);
    send_frame(8'h56, 1'b0, 1'b0, 1'b1);
    send_frame(8'h78, 1'b0, 1'b0, 1'b1);
    send_frame(8'h9A, 1'b0, 1'b0, 1'b1);
    repeat (10) step();
    chk("burst_valid", int'(rx_valid), 1);
    chk("burst_ovr", n_ovr, 1);
    rx_ready = 1'b1;
    wait_drain("burst_drain");
    repeat (2) step();
    chk("burst_empty", int'(rx_valid), 0);
    chk_counts("burst");

    // Glitch rejection
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy) saw_busy = 1'b1;
    end
    chk("glitch_busy_seen", int'(saw_busy), 1);
    chk("glitch_idle", int'(busy), 0);
    chk("glitch_valid", int'(rx_valid), 0);
    chk_counts("glitch");

    // Framing error, held break, then recovery
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) step();
    chk("break_busy", int'(busy), 1);
    chk("break_valid", int'(rx_valid), 0);
    rx = 1'b1;
    repeat (6) step();
    chk("break_exit", int'(busy), 0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    wait_drain("frame_drain");
    chk_counts("frame");

    // Odd parity: good then bad parity bit
    parity_en  = 1'b1;
    parity_odd = 1'b1;
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    wait_drain("parity_drain");
    chk_counts("parity");

    // Reset during data bit 4 at 64 clocks/bit
    parity_en = 1'b0;
    baud_div  = 16'd3;
    repeat (8) step();
    fb = frame_bits(8'hC3, 1'b0, 1'b0, 1'b1);
    drive_bits(fb, 5);
    rx = fb[5];
    repeat (20) step();
    chk("mid_busy", int'(busy), 1);
    io_rst = 1'b1;
    rx     = 1'b1;
    step();
    chk("mrst_valid", int'(rx_valid), 0);
    chk("mrst_data", int'(rx_data), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_errs", int'({frame_err, parity_err, overrun}), 0);
    io_rst = 1'b0;
    repeat (10) step();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    wait_drain("reset_drain");
    chk_counts("reset");

    // Randomised frames, random consumer stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      repeat (6) step();
      baud_div   = 16'($urandom_range(0, 2));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      d          = 8'($urandom_range(0, 255));
      pbit       = 1'($urandom_range(0, 1));
      stop       = ($urandom_range(0, 7) != 0);
      pen        = parity_en;
      send_frame(d, pen, pbit, stop);
      repeat (4) step();
    end
    rand_ready = 1'b0;
    rx_ready   = 1'b1;
    wait_drain("random_drain");
    chk_counts("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial UART receiver with a small buffered output. It consumes the USART1_RX line that the system testbench drives (8 data bits, LSB first, idle-high) and delivers received bytes over a valid/ready interface to the SoC peripheral bus. It sits directly downstream of the pad/GPIO mux and upstream of the USART register block. It uses 16x oversampling with majority-vote sampling, optional parity checking, error flags and an N-deep receive FIFO.

Parameters:
FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2 and at least 2.
DIV_W, 16, width of the baud divisor input.

Ports:
io_clk  in  1  system clock; all logic is on the rising edge.
io_rst  in  1  synchronous reset, active-high.
baud_div  in  DIV_W  clocks per oversample tick minus 1. Value 0 gives a tick every clock. Change only while busy=0.
parity_en  in  1  1: a parity bit follows the data bits.
parity_odd  in  1  1: odd parity; 0: even parity.
rx  in  1  asynchronous serial input, idle high.
rx_data  out  8  byte at the FIFO head.
rx_valid  out  1  FIFO not empty.
rx_ready  in  1  consumer accepts rx_data when rx_valid=1 and rx_ready=1.
frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
parity_err  out  1  one-cycle pulse: parity mismatch.
overrun  out  1  one-cycle pulse: byte dropped because the FIFO was full.
busy  out  1  receiver state is not IDLE.

Behaviour:
- Reset (synchronous, io_rst=1 at a clock edge):
  - State goes to IDLE; the FIFO is emptied; the tick and sample counters clear.
  - Both synchroniser flops are set to 1.
  - rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
  - Reset during a frame abandons the frame; no partial byte is ever pushed.
- Input synchroniser:
  - rx passes through 2 flops to give rx_s.
  - All decisions use rx_s, so there are 2 cycles of input latency.
- Tick generator:
  - The counter counts 0..baud_div; a tick is asserted on the cycle the count equals baud_div, then the count reloads to 0.
  - The counter is free-running in every state.
- Sample counter s:
  - 4 bits; increments on each tick while not IDLE; wraps 15 to 0.
- State machine: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on a tick with rx_s=0, go to START with s=0.
  - All states: samples are taken at s=7, 8 and 9. The bit value is the majority of the 3 samples and is decided on the s=9 tick.
  - START: majority=1 means a glitch; go to IDLE on that tick. Otherwise go to DATA at the s=15 tick, with bit index 0.
  - DATA: on each s=9 tick, shift the majority bit in LSB-first. After the 8th bit's s=15 tick, go to PARITY if parity_en=1, else go to STOP.
  - PARITY: on the s=9 tick, compute expected = XOR(data) XOR parity_odd. Store the mismatch flag. Go to STOP at s=15.
  - STOP, majority=1: on the s=9 tick, push the byte and go to IDLE. Exiting at mid-stop allows back-to-back frames.
  - STOP, majority=0: pulse frame_err; discard the byte; go to BREAK.
  - A stored parity mismatch pulses parity_err on the STOP s=9 tick. The byte is still pushed if the stop bit is valid.
  - BREAK: stay until rx_s=1, then go to IDLE on the next clock.
- FIFO:
  - rx_valid=1 whenever count>0; rx_data shows the head entry.
  - A push becomes visible the cycle after the push cycle: rx_valid and rx_data update then.
  - Pop happens on rx_valid & rx_ready.
  - Push while full without a same-cycle pop: the byte is dropped, overrun pulses for 1 cycle, contents are unchanged.
  - Push while full with a same-cycle pop: the pop frees a slot, the push is accepted, and there is no overrun.
  - Pointers wrap modulo FIFO_DEPTH; count range is 0..FIFO_DEPTH.
  - rx_data holds its last value when the FIFO is empty.
- Error pulses can coincide; for example, parity_err and overrun can pulse in the same cycle.

Test Plan:
- Basic receive: baud_div=0 (16 clocks/bit), rx_ready=1; send 0xAA, 8N1 -> one rx_valid with rx_data=0xAA; no error pulses; busy=0 after mid-stop.
- Back-to-back burst: rx_ready=0; send 0x12, 0x34, 0x56, 0x78, 0x9A consecutively -> 4 entries stored and overrun pulses once on the 5th; reading then yields 0x12, 0x34, 0x56, 0x78 in order, then rx_valid=0.
- Glitch rejection: rx low for 4 clocks only, baud_div=0 -> busy pulses, then IDLE; no rx_valid; no errors.
- Framing error: send 0x3C with stop=0, then hold rx low for 40 clocks, then return high and send 0x01 -> frame_err pulses once; 0x3C not pushed; state stays in BREAK until rx high; then 0x01 is received.
- Parity: parity_en=1, parity_odd=1; send 0x55 with parity bit 1 -> valid 0x55, no error. Send 0x55 with parity bit 0 -> parity_err pulse and 0x55 still pushed.
- Reset mid-frame and divisor: baud_div=3; assert io_rst during DATA bit 4 -> all outputs 0, FIFO empty. A fresh 0xC3 is then received correctly at 64 clocks/bit.
